// File: rtl/draw_axi_pkg.sv
// Shared definitions for the draw-side AXI4 masters.
// Contents:
//   arb_state_t    - write/read arbiter phase (idle, address, data, response)
//   AXI_MAX_BURST  - longest AXI4 INCR burst in beats
//   DRAW_AXI_AW/DW - default address/data widths of the VRAM port
//   burst_is_last  - last-beat predicate shared by beat counters
package draw_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } arb_state_t;

    localparam int AXI_MAX_BURST = 256;
    localparam int DRAW_AXI_AW   = 32;
    localparam int DRAW_AXI_DW   = 32;

    // A beat is the last one when the zero-based beat count equals AWLEN.
    function automatic logic burst_is_last(input logic [7:0] beat, input logic [7:0] len);
        return (beat == len);
    endfunction

endpackage

// File: rtl/draw_rr_arb.sv
// Combinational round-robin pick among up to four requesters.
// Ports:
//   req      - request vector, one bit per requester
//   last_idx - index granted most recently; search starts just after it
//   gnt_idx  - chosen requester (0 when nothing is requested)
//   any_req  - at least one request bit is set
import draw_axi_pkg::*;

module draw_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_idx,
    output logic [1:0]      gnt_idx,
    output logic            any_req
);

    logic found_s;
    int   idx_s;

    // Walk last+1, last+2, ... modulo NREQ and keep the first asserted request.
    always_comb begin
        gnt_idx = 2'd0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = (int'(last_idx) + k) % NREQ;
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                gnt_idx = 2'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/draw_wr_arb.sv
// Shares the VRAM AXI4 write master among NREQ draw engines, one burst at a
// time, round-robin at burst granularity. A grant lasts from the AW handshake
// through the B handshake; non-granted requesters see all readies/valids low.
// Ports:
//   CLK, ARST                 - clock, synchronous active-high reset
//   S_AW*/S_W*/S_B*           - packed per-requester AXI write channels
//   M_AXI_*                   - single downstream AXI write master
//   GNT_IDX                   - current / most recent grant
//   ARB_BUSY                  - arbiter not idle (to draw status register)
//   PROTO_ERR, ERR_CLR        - sticky requester WLAST/AWLEN mismatch and its clear
import draw_axi_pkg::*;

module draw_wr_arb #(
    parameter int NREQ = 2,
    parameter int AW   = DRAW_AXI_AW,
    parameter int DW   = DRAW_AXI_DW
) (
    input  logic                 CLK,
    input  logic                 ARST,
    input  logic [NREQ*AW-1:0]   S_AWADDR,
    input  logic [NREQ*8-1:0]    S_AWLEN,
    input  logic [NREQ-1:0]      S_AWVALID,
    output logic [NREQ-1:0]      S_AWREADY,
    input  logic [NREQ*DW-1:0]   S_WDATA,
    input  logic [NREQ*DW/8-1:0] S_WSTRB,
    input  logic [NREQ-1:0]      S_WLAST,
    input  logic [NREQ-1:0]      S_WVALID,
    output logic [NREQ-1:0]      S_WREADY,
    output logic [NREQ-1:0]      S_BVALID,
    input  logic [NREQ-1:0]      S_BREADY,
    output logic [AW-1:0]        M_AXI_AWADDR,
    output logic [7:0]           M_AXI_AWLEN,
    output logic                 M_AXI_AWVALID,
    input  logic                 M_AXI_AWREADY,
    output logic [DW-1:0]        M_AXI_WDATA,
    output logic [DW/8-1:0]      M_AXI_WSTRB,
    output logic                 M_AXI_WLAST,
    output logic                 M_AXI_WVALID,
    input  logic                 M_AXI_WREADY,
    input  logic                 M_AXI_BVALID,
    output logic                 M_AXI_BREADY,
    output logic [1:0]           GNT_IDX,
    output logic                 ARB_BUSY,
    output logic                 PROTO_ERR,
    input  logic                 ERR_CLR
);

    localparam int SW = DW / 8;

    arb_state_t     state_r, state_nxt_s;
    logic [1:0]     gnt_r, last_r, pick_s;
    logic           any_s;
    logic [7:0]     len_r, beat_r;
    logic           err_r;

    logic [AW-1:0]  sel_awaddr_s;
    logic [7:0]     sel_awlen_s;
    logic           sel_awvalid_s, sel_wlast_s, sel_wvalid_s, sel_bready_s;
    logic [DW-1:0]  sel_wdata_s;
    logic [SW-1:0]  sel_wstrb_s;
    logic           in_addr_s, in_data_s, in_resp_s;
    logic           wlast_s, aw_hs_s, w_hs_s, b_hs_s;

    draw_rr_arb #(.NREQ(NREQ)) u_rr (
        .req      (S_AWVALID),
        .last_idx (last_r),
        .gnt_idx  (pick_s),
        .any_req  (any_s)
    );

    assign in_addr_s = (state_r == S_ADDR);
    assign in_data_s = (state_r == S_DATA);
    assign in_resp_s = (state_r == S_RESP);
    assign wlast_s   = burst_is_last(beat_r, len_r);
    assign aw_hs_s   = in_addr_s & sel_awvalid_s & M_AXI_AWREADY;
    assign w_hs_s    = in_data_s & sel_wvalid_s & M_AXI_WREADY;
    assign b_hs_s    = in_resp_s & M_AXI_BVALID & sel_bready_s;

    // Select the granted requester's channel signals.
    always_comb begin
        sel_awaddr_s  = '0;
        sel_awlen_s   = 8'd0;
        sel_awvalid_s = 1'b0;
        sel_wdata_s   = '0;
        sel_wstrb_s   = '0;
        sel_wlast_s   = 1'b0;
        sel_wvalid_s  = 1'b0;
        sel_bready_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_r == 2'(i)) begin
                sel_awaddr_s  = S_AWADDR[i*AW +: AW];
                sel_awlen_s   = S_AWLEN[i*8 +: 8];
                sel_awvalid_s = S_AWVALID[i];
                sel_wdata_s   = S_WDATA[i*DW +: DW];
                sel_wstrb_s   = S_WSTRB[i*SW +: SW];
                sel_wlast_s   = S_WLAST[i];
                sel_wvalid_s  = S_WVALID[i];
                sel_bready_s  = S_BREADY[i];
            end else begin
                sel_bready_s  = sel_bready_s;
            end
        end
    end

    // Route downstream handshakes back to the granted requester only, gated by phase.
    always_comb begin
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_r == 2'(i)) begin
                S_AWREADY[i] = in_addr_s & M_AXI_AWREADY;
                S_WREADY[i]  = in_data_s & M_AXI_WREADY;
                S_BVALID[i]  = in_resp_s & M_AXI_BVALID;
            end else begin
                S_AWREADY[i] = 1'b0;
                S_WREADY[i]  = 1'b0;
                S_BVALID[i]  = 1'b0;
            end
        end
    end

    assign M_AXI_AWADDR  = sel_awaddr_s;
    assign M_AXI_AWLEN   = sel_awlen_s;
    assign M_AXI_AWVALID = in_addr_s & sel_awvalid_s;
    assign M_AXI_WDATA   = sel_wdata_s;
    assign M_AXI_WSTRB   = sel_wstrb_s;
    // WLAST comes from our own beat counter; the requester's flag is only checked.
    assign M_AXI_WLAST   = in_data_s & wlast_s;
    assign M_AXI_WVALID  = in_data_s & sel_wvalid_s;
    assign M_AXI_BREADY  = in_resp_s & sel_bready_s;
    assign GNT_IDX       = gnt_r;
    assign ARB_BUSY      = (state_r != S_IDLE);
    assign PROTO_ERR     = err_r;

    // Phase sequencing: idle -> address -> data -> response -> idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (any_s) state_nxt_s = S_ADDR;
                else       state_nxt_s = S_IDLE;
            end
            S_ADDR: begin
                if (aw_hs_s) state_nxt_s = S_DATA;
                else         state_nxt_s = S_ADDR;
            end
            S_DATA: begin
                if (w_hs_s && wlast_s) state_nxt_s = S_RESP;
                else                   state_nxt_s = S_DATA;
            end
            S_RESP: begin
                if (b_hs_s) state_nxt_s = S_IDLE;
                else        state_nxt_s = S_RESP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, grant bookkeeping, beat counting and the sticky protocol error.
    always_ff @(posedge CLK) begin
        if (ARST) begin
            state_r <= S_IDLE;
            gnt_r   <= 2'd0;
            last_r  <= 2'(NREQ - 1);
            len_r   <= 8'd0;
            beat_r  <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_IDLE && any_s) gnt_r <= pick_s;
            if (aw_hs_s) begin
                len_r  <= sel_awlen_s;
                beat_r <= 8'd0;
            end else if (w_hs_s && !wlast_s) begin
                // Hold on the last beat so a 256-beat burst never wraps the counter.
                beat_r <= beat_r + 8'd1;
            end
            if (b_hs_s) last_r <= gnt_r;
            // A new mismatch takes priority over a simultaneous clear.
            if (w_hs_s && (sel_wlast_s != wlast_s)) err_r <= 1'b1;
            else if (ERR_CLR)                       err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_wr_arb.sv
// Bench for draw_wr_arb: bench-driven requesters and downstream slave, a
// burst-level reference model compared every cycle, plus literal checks of
// the scenarios (single burst, alternation, long burst, WLAST mismatch,
// random backpressure, mid-burst reset).
module tb_draw_wr_arb;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                 CLK = 1'b0;
    logic                 ARST;
    logic [NREQ*AW-1:0]   S_AWADDR;
    logic [NREQ*8-1:0]    S_AWLEN;
    logic [NREQ-1:0]      S_AWVALID, S_AWREADY;
    logic [NREQ*DW-1:0]   S_WDATA;
    logic [NREQ*SW-1:0]   S_WSTRB;
    logic [NREQ-1:0]      S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic [AW-1:0]        M_AXI_AWADDR;
    logic [7:0]           M_AXI_AWLEN;
    logic                 M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0]        M_AXI_WDATA;
    logic [SW-1:0]        M_AXI_WSTRB;
    logic                 M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic                 M_AXI_BVALID, M_AXI_BREADY;
    logic [1:0]           GNT_IDX;
    logic                 ARB_BUSY, PROTO_ERR, ERR_CLR;

    always #5 CLK = ~CLK;

    draw_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .ARST(ARST),
        .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .GNT_IDX(GNT_IDX), .ARB_BUSY(ARB_BUSY), .PROTO_ERR(PROTO_ERR), .ERR_CLR(ERR_CLR)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] base;
        int          bad;   // beat index whose S_WLAST is inverted, -1 for none
    } burst_t;

    burst_t rq[NREQ][$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the burst currently owning the master, if any.
    bit m_active, m_aw_done, m_err;
    int m_owner, m_last, m_gnt, m_beats, m_len;
    int mon_beats, mon_lastpos;
    int log_owner[$], log_beats[$], log_lastpos[$];

    // Handshakes seen at the last falling edge, consumed by the drivers.
    bit hs_aw[NREQ], hs_w[NREQ], hs_b[NREQ];
    bit hs_mw_last, hs_mb, rst_seen;
    bit d_awd[NREQ];
    int d_beat[NREQ];
    int bq;
    bit bp_on, errclr_force;

    function automatic logic [31:0] bdata(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] bstrb(input logic [31:0] base, input int k);
        return base[3:0] ^ 4'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_aw_done = 1'b0; m_err = 1'b0;
        m_owner = 0; m_last = NREQ - 1; m_gnt = 0; m_beats = 0; m_len = 0;
        mon_beats = 0; mon_lastpos = 0;
    endtask

    // Compare every cycle against the model, then advance the model past the next edge.
    always @(negedge CLK) begin
        logic [NREQ-1:0] e_awr, e_wr, e_bv;
        logic            e_awv, e_wv, e_br, new_err;
        int              o;
        for (int r = 0; r < NREQ; r++) begin
            hs_aw[r] = S_AWVALID[r] && S_AWREADY[r];
            hs_w[r]  = S_WVALID[r] && S_WREADY[r];
            hs_b[r]  = S_BVALID[r] && S_BREADY[r];
        end
        hs_mw_last = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
        hs_mb      = M_AXI_BVALID && M_AXI_BREADY;
        rst_seen   = ARST;

        e_awr = '0; e_wr = '0; e_bv = '0;
        e_awv = 1'b0; e_wv = 1'b0; e_br = 1'b0;
        o = m_owner;
        if (m_active && !m_aw_done) begin
            e_awv = S_AWVALID[o]; e_awr[o] = M_AXI_AWREADY;
        end else if (m_active && m_beats <= m_len) begin
            e_wv = S_WVALID[o]; e_wr[o] = M_AXI_WREADY;
        end else if (m_active) begin
            e_br = S_BREADY[o]; e_bv[o] = M_AXI_BVALID;
        end
        chk("arb_busy", 64'(ARB_BUSY), 64'(m_active));
        chk("gnt_idx", 64'(GNT_IDX), 64'(m_gnt));
        chk("proto_err", 64'(PROTO_ERR), 64'(m_err));
        chk("m_awvalid", 64'(M_AXI_AWVALID), 64'(e_awv));
        chk("s_awready", 64'(S_AWREADY), 64'(e_awr));
        chk("m_wvalid", 64'(M_AXI_WVALID), 64'(e_wv));
        chk("s_wready", 64'(S_WREADY), 64'(e_wr));
        chk("m_bready", 64'(M_AXI_BREADY), 64'(e_br));
        chk("s_bvalid", 64'(S_BVALID), 64'(e_bv));
        if (e_awv && rq[o].size() > 0) begin
            chk("m_awaddr", 64'(M_AXI_AWADDR), 64'(rq[o][0].addr));
            chk("m_awlen", 64'(M_AXI_AWLEN), 64'(rq[o][0].len));
        end
        if (e_wv && rq[o].size() > 0) begin
            chk("m_wdata", 64'(M_AXI_WDATA), 64'(bdata(rq[o][0].base, m_beats)));
            chk("m_wstrb", 64'(M_AXI_WSTRB), 64'(bstrb(rq[o][0].base, m_beats)));
            chk("m_wlast", 64'(M_AXI_WLAST), 64'(m_beats == m_len));
        end

        if (M_AXI_WVALID && M_AXI_WREADY) begin
            mon_beats++;
            if (M_AXI_WLAST) mon_lastpos = mon_beats;
        end

        new_err = 1'b0;
        if (ARST) begin
            model_reset();
        end else if (!m_active) begin
            for (int k = 1; k <= NREQ && !m_active; k++) begin
                if (S_AWVALID[(m_last + k) % NREQ]) begin
                    m_active = 1'b1; m_aw_done = 1'b0;
                    m_owner = (m_last + k) % NREQ; m_gnt = m_owner;
                end
            end
        end else if (!m_aw_done) begin
            if (S_AWVALID[o] && M_AXI_AWREADY) begin
                m_aw_done = 1'b1; m_len = int'(S_AWLEN[o*8 +: 8]); m_beats = 0;
                mon_beats = 0; mon_lastpos = 0;
            end
        end else if (m_beats <= m_len) begin
            if (S_WVALID[o] && M_AXI_WREADY) begin
                new_err = (S_WLAST[o] != (m_beats == m_len));
                m_beats++;
            end
        end else if (M_AXI_BVALID && S_BREADY[o]) begin
            chk("burst_beats", 64'(mon_beats), 64'(m_len + 1));
            chk("burst_lastpos", 64'(mon_lastpos), 64'(m_len + 1));
            log_owner.push_back(o); log_beats.push_back(mon_beats); log_lastpos.push_back(mon_lastpos);
            m_active = 1'b0; m_last = o;
        end
        if (!ARST) begin
            if (new_err)      m_err = 1'b1;
            else if (ERR_CLR) m_err = 1'b0;
        end
    end

    // Requester engines and downstream slave, driven just after each rising edge.
    always @(posedge CLK) begin
        burst_t cb;
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (rst_seen) begin
                rq[r].delete(); d_awd[r] = 1'b0; d_beat[r] = 0; S_WVALID[r] = 1'b0;
            end else begin
                if (hs_b[r]) begin
                    rq[r].delete(0); d_awd[r] = 1'b0; d_beat[r] = 0;
                end
                if (hs_aw[r]) d_awd[r] = 1'b1;
                if (hs_w[r])  d_beat[r]++;
            end
            if (rq[r].size() > 0) begin
                cb = rq[r][0];
                S_AWVALID[r] = !d_awd[r];
                S_AWADDR[r*AW +: AW] = cb.addr;
                S_AWLEN[r*8 +: 8] = cb.len;
                if (d_beat[r] <= int'(cb.len)) begin
                    if (!(S_WVALID[r] && !hs_w[r]))
                        S_WVALID[r] = bp_on ? ($urandom_range(3) != 0) : 1'b1;
                    S_WDATA[r*DW +: DW] = bdata(cb.base, d_beat[r]);
                    S_WSTRB[r*SW +: SW] = bstrb(cb.base, d_beat[r]);
                    S_WLAST[r] = (d_beat[r] == int'(cb.len)) ^ (d_beat[r] == cb.bad);
                end else begin
                    S_WVALID[r] = 1'b0; S_WLAST[r] = 1'b0;
                end
                S_BREADY[r] = (d_awd[r] && d_beat[r] > int'(cb.len)) ?
                              (bp_on ? 1'($urandom_range(1)) : 1'b1) : 1'b0;
            end else begin
                S_AWVALID[r] = 1'b0; S_WVALID[r] = 1'b0; S_WLAST[r] = 1'b0; S_BREADY[r] = 1'b0;
            end
        end
        if (rst_seen) begin
            bq = 0; M_AXI_BVALID = 1'b0;
        end else begin
            if (hs_mw_last) bq++;
            if (hs_mb) bq--;
        end
        M_AXI_AWREADY = bp_on ? 1'($urandom_range(1)) : 1'b1;
        M_AXI_WREADY  = bp_on ? 1'($urandom_range(1)) : 1'b1;
        if (!(M_AXI_BVALID && !hs_mb))
            M_AXI_BVALID = (bq > 0) && (bp_on ? ($urandom_range(1) == 1) : 1'b1);
        ERR_CLR = errclr_force | (bp_on && $urandom_range(7) == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic push(input int r, input logic [31:0] a, input logic [7:0] l, input logic [31:0] b, input int bad);
        burst_t x;
        x.addr = a; x.len = l; x.base = b; x.bad = bad;
        rq[r].push_back(x);
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || m_active) && cyc < budget) begin
            tick(1); cyc++;
        end
        n_tests++;
        if (cyc >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, cyc);
        end
    endtask

    task automatic clear_logs();
        log_owner.delete(); log_beats.delete(); log_lastpos.delete();
    endtask

    task automatic do_reset();
        ARST = 1'b1; tick(2); ARST = 1'b0; tick(1);
    endtask

    initial begin
        int cnt;
        int exp2[4];
        ARST = 1'b1; bp_on = 1'b0; errclr_force = 1'b0; bq = 0;
        S_AWADDR = '0; S_AWLEN = '0; S_AWVALID = '0; S_WDATA = '0; S_WSTRB = '0;
        S_WLAST = '0; S_WVALID = '0; S_BREADY = '0; ERR_CLR = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        for (int r = 0; r < NREQ; r++) begin d_awd[r] = 1'b0; d_beat[r] = 0; end
        model_reset();
        tick(3);
        chk("reset_busy", 64'(ARB_BUSY), 64'd0);
        chk("reset_gnt", 64'(GNT_IDX), 64'd0);
        chk("reset_err", 64'(PROTO_ERR), 64'd0);
        chk("reset_awvalid", 64'(M_AXI_AWVALID), 64'd0);
        ARST = 1'b0; tick(1);

        // Single burst from req0: driver raises AWVALID one cycle after the push,
        // the arbiter answers one cycle later.
        clear_logs();
        push(0, 32'h0000_1000, 8'd3, 32'hA000_0000, -1);
        cnt = 0;
        while (!M_AXI_AWVALID && cnt < 20) begin tick(1); cnt++; end
        chk("aw_latency", 64'(cnt), 64'd2);
        chk("t1_awaddr", 64'(M_AXI_AWADDR), 64'h1000);
        wait_done("t1", 100);
        chk("t1_count", 64'(log_owner.size()), 64'd1);
        if (log_owner.size() == 1) begin
            chk("t1_owner", 64'(log_owner[0]), 64'd0);
            chk("t1_beats", 64'(log_beats[0]), 64'd4);
            chk("t1_lastpos", 64'(log_lastpos[0]), 64'd4);
        end

        // Both requesters with two bursts each: strict alternation from req0.
        do_reset(); clear_logs();
        for (int i = 0; i < 2; i++) begin
            push(0, 32'h2000 + 32'(i*16), 8'd1, 32'h1100_0000 + 32'(i), -1);
            push(1, 32'h3000 + 32'(i*16), 8'd1, 32'h2200_0000 + 32'(i), -1);
        end
        wait_done("t2", 200);
        exp2 = '{0, 1, 0, 1};
        chk("t2_count", 64'(log_owner.size()), 64'd4);
        if (log_owner.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_order", 64'(log_owner[i]), 64'(exp2[i]));

        // 256-beat burst from req1 stalls req0 until its response.
        clear_logs();
        push(1, 32'h0004_0000, 8'd255, 32'h3300_0000, -1);
        cnt = 0;
        while (!(m_active && m_owner == 1) && cnt < 20) begin tick(1); cnt++; end
        push(0, 32'h0005_0000, 8'd0, 32'h4400_0000, -1);
        wait_done("t3", 2000);
        chk("t3_count", 64'(log_owner.size()), 64'd2);
        if (log_owner.size() == 2) begin
            chk("t3_owner0", 64'(log_owner[0]), 64'd1);
            chk("t3_beats0", 64'(log_beats[0]), 64'd256);
            chk("t3_lastpos0", 64'(log_lastpos[0]), 64'd256);
            chk("t3_owner1", 64'(log_owner[1]), 64'd0);
            chk("t3_beats1", 64'(log_beats[1]), 64'd1);
        end
        chk("t3_err", 64'(PROTO_ERR), 64'd0);

        // Early WLAST from req0: error flagged, burst still ends on beat 3.
        clear_logs();
        push(0, 32'h0006_0000, 8'd2, 32'h5500_0000, 1);
        wait_done("t4", 100);
        chk("t4_err", 64'(PROTO_ERR), 64'd1);
        if (log_owner.size() == 1) begin
            chk("t4_beats", 64'(log_beats[0]), 64'd3);
            chk("t4_lastpos", 64'(log_lastpos[0]), 64'd3);
        end
        errclr_force = 1'b1; tick(1); errclr_force = 1'b0; tick(1);
        chk("t4_err_clr", 64'(PROTO_ERR), 64'd0);

        // Random mixed bursts under 50% backpressure.
        clear_logs(); bp_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int r, l, bad;
            r = $urandom_range(1);
            l = $urandom_range(15);
            bad = ($urandom_range(9) == 0) ? $urandom_range(l) : -1;
            push(r, 32'h0010_0000 + 32'(i*64), 8'(l), $urandom, bad);
        end
        wait_done("t5", 40000);
        chk("t5_count", 64'(log_owner.size()), 64'd100);
        bp_on = 1'b0; tick(2);

        // Reset in the middle of a req1 data phase, then req0 wins first.
        clear_logs();
        push(1, 32'h0007_0000, 8'd7, 32'h6600_0000, -1);
        cnt = 0;
        while (!(m_active && m_aw_done && m_beats >= 3) && cnt < 50) begin tick(1); cnt++; end
        ARST = 1'b1; tick(1);
        chk("t6_busy", 64'(ARB_BUSY), 64'd0);
        chk("t6_wvalid", 64'(M_AXI_WVALID), 64'd0);
        chk("t6_wready", 64'(S_WREADY), 64'd0);
        chk("t6_gnt", 64'(GNT_IDX), 64'd0);
        ARST = 1'b0;
        clear_logs();
        push(0, 32'h0008_0000, 8'd1, 32'h7700_0000, -1);
        push(1, 32'h0009_0000, 8'd1, 32'h8800_0000, -1);
        wait_done("t6", 200);
        chk("t6_count", 64'(log_owner.size()), 64'd2);
        if (log_owner.size() == 2) begin
            chk("t6_first", 64'(log_owner[0]), 64'd0);
            chk("t6_second", 64'(log_owner[1]), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
